fetch_stage: RTL
================

# fetch_stage

Instruction fetch stage of the 5-stage MiniMIPS pipeline. It owns the program counter and drives the address of the combinational instruction memory. It captures the returned word, together with PC+4, into the IF/ID pipeline register. It honours stall, flush and branch/jump redirect from the hazard and branch logic, and stops fetching once a halt instruction has been captured.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- HALT_INSTR, 32'hFC00_0000, instruction word (opcode 0x3F) that stops fetch.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- imem_addr  out  32  fetch address to instruction memory; always equals current PC.
- imem_rdata  in  32  instruction word returned combinationally for imem_addr.
- stall  in  1  hold PC and IF/ID (load-use hazard).
- flush  in  1  squash IF/ID contents (insert bubble).
- redirect  in  1  taken branch/jump; load PC from redirect_pc.
- redirect_pc  in  32  redirect target.
- if_id_instr  out  32  registered instruction to decode.
- if_id_pc4  out  32  registered PC+4 of that instruction.
- if_id_valid  out  1  IF/ID holds a real instruction.
- halted  out  1  FSM is in HALT.
- misalign_err  out  1  sticky misaligned-redirect flag (see Configuration).

## Operation
- Internal state: pc[31:0], IF/ID registers, FSM {RUN, HALT}.
- imem_addr = pc. This path is combinational, with no register between pc and imem_addr.
- pc4 = pc + 4, modulo 2^32. 32'hFFFF_FFFC wraps to 32'h0000_0000.
- PC next-state, in priority order:
  - redirect: pc <= {redirect_pc[31:2], 2'b00}.
  - HALT or stall: pc holds.
  - otherwise: pc <= pc4.
- IF/ID next-state, in priority order:
  - flush: instr <= 0, pc4 <= 0, valid <= 0.
  - stall: all fields hold.
  - HALT: instr <= 0, pc4 <= 0, valid <= 0.
  - otherwise: instr <= imem_rdata, pc4 <= pc4, valid <= 1.
- FSM transitions:
  - RUN -> HALT when the IF/ID load in that cycle captures imem_rdata == HALT_INSTR. In HALT, pc freezes at the halt instruction's address + 4.
  - HALT -> RUN on redirect. This case is a speculatively fetched halt squashed by an older branch; fetch resumes at redirect_pc.
  - flush without redirect in HALT: IF/ID is cleared and the FSM stays in HALT.
  - Otherwise HALT persists until reset.
- halted = (state == HALT).
- Simultaneous stall and redirect: redirect wins for pc. IF/ID follows its own priority (flush, then stall).
- Simultaneous stall and flush: a bubble is inserted and pc holds.

## Timing
- Reset (asynchronous, rst_n = 0):
  - pc = RESET_PC, so imem_addr = RESET_PC immediately.
  - if_id_instr = 0, if_id_pc4 = 0, if_id_valid = 0.
  - FSM = RUN, halted = 0, misalign_err = 0.
- Reset is released synchronously to the pipeline. The first rising edge with rst_n = 1 loads MEM[RESET_PC] into IF/ID.
- Latency: the word at address A appears on if_id_instr one edge after pc == A.
- Throughput: one instruction per cycle when stall, flush and redirect are all 0.
- Redirect: the target is presented on imem_addr in the cycle after redirect is sampled. The instruction already in flight is discarded only if flush is asserted in the same cycle; the hazard unit asserts both.
- Reset asserted mid-operation overrides every state and register, regardless of stall, flush or HALT.

## Configuration
- IF_ALIGN_CHECK_EN defined:
  - misalign_err is set on any edge where redirect = 1 and redirect_pc[1:0] != 0.
  - It is sticky and cleared only by rst_n.
  - pc still loads the aligned target.
- IF_ALIGN_CHECK_EN undefined:
  - misalign_err is tied to 0.
  - Low target bits are silently dropped.
  - The port is present in both builds.

## Test plan
- Reset, then run 4 cycles with memory holding 012A4020, 01095820, 016A6022, 00000000 at addresses 0..12:
  - if_id_instr sequence 012A4020, 01095820, 016A6022, 00000000.
  - if_id_pc4 sequence 4, 8, C, 10.
  - valid = 1 from the first edge.
- Stall high for 2 cycles while pc = 8: pc stays 8 and IF/ID holds 01095820 (pc4 = 8). Fetch resumes with 016A6022 afterwards.
- Redirect with redirect_pc = 0x40 plus flush at pc = 8: the next edge gives if_id_valid = 0 and pc = 0x40. The following edge gives pc4 = 0x44.
- HALT_INSTR placed at address 0x10: halted rises on the edge capturing it, pc freezes at 0x14, and later if_id_valid = 0. A subsequent redirect to 0x0 with flush returns to RUN and refetches 012A4020.
- Redirect_pc = 0x42 with IF_ALIGN_CHECK_EN: pc = 0x40 and misalign_err = 1, which stays set until rst_n is pulsed. Without the macro, misalign_err stays 0.
- rst_n pulsed low mid-stall while in HALT: all outputs return to their reset values asynchronously and pc = RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// MiniMIPS instruction fetch: PC, IF/ID register and RUN/HALT control.
// Optional feature macro: IF_ALIGN_CHECK_EN (sticky misaligned-redirect flag).
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] HALT_INSTR = 32'hFC00_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        halted,
    output logic        misalign_err
);

    typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc4;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ifpc4_q, ifpc4_d;
    logic        valid_q, valid_d;
    logic        load_en;

    assign pc4       = pc_q + 32'd4;
    assign load_en   = (state_q == RUN) && !stall && !flush;
    assign imem_addr = pc_q;

    always_comb begin
        if (redirect)
            pc_d = {redirect_pc[31:2], 2'b00};
        else if (state_q == HALT || stall)
            pc_d = pc_q;
        else
            pc_d = pc4;
    end

    // Flush outranks stall so a stalled slot can still be turned into a bubble.
    always_comb begin
        instr_d = instr_q;
        ifpc4_d = ifpc4_q;
        valid_d = valid_q;
        if (flush || (!stall && state_q == HALT)) begin
            instr_d = 32'd0;
            ifpc4_d = 32'd0;
            valid_d = 1'b0;
        end else if (!stall) begin
            instr_d = imem_rdata;
            ifpc4_d = pc4;
            valid_d = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:  if (load_en && imem_rdata == HALT_INSTR) state_d = HALT;
            HALT: if (redirect) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            ifpc4_q <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ifpc4_q <= ifpc4_d;
            valid_q <= valid_d;
        end
    end

`ifdef IF_ALIGN_CHECK_EN
    logic misalign_q, misalign_d;

    assign misalign_d = misalign_q | (redirect && (redirect_pc[1:0] != 2'b00));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            misalign_q <= 1'b0;
        else
            misalign_q <= misalign_d;
    end

    assign misalign_err = misalign_q;
`else
    logic unused_low_bits;

    assign unused_low_bits = ^redirect_pc[1:0];
    assign misalign_err    = 1'b0;
`endif

    assign if_id_instr = instr_q;
    assign if_id_pc4   = ifpc4_q;
    assign if_id_valid = valid_q;
    assign halted      = (state_q == HALT);

endmodule
